// File: rtl/bus_enc_pkg.sv
// bus_enc_pkg: shared types and helpers for the bus-select encoder
package bus_enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_SINGLE,
        CLS_CONFLICT
    } req_class_e;

    // All-ones select value meaning "no source on the bus"
    function automatic int unsigned idle_code(input int unsigned sel_w);
        return (1 << sel_w) - 1;
    endfunction

    // A lone bit only counts as a single request when it maps to a real source
    function automatic req_class_e classify(input int unsigned ones, input logic out_of_range);
        if (ones == 0)
            return CLS_ZERO;
        else if (ones == 1 && !out_of_range)
            return CLS_SINGLE;
        else
            return CLS_CONFLICT;
    endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// onehot_prio_enc: classifies the request vector and resolves it to a source index
module onehot_prio_enc
    import bus_enc_pkg::*;
#(
    parameter int IN_W     = 32,
    parameter int N_SRC    = 24,
    parameter int SEL_W    = 5,
    parameter int PRIORITY = 0
) (
    input  logic [IN_W-1:0]  req,
    output logic [SEL_W-1:0] index,
    output logic             is_zero,
    output logic             is_conflict
);

    localparam logic [SEL_W-1:0] IDLE_CODE = SEL_W'(idle_code(SEL_W));

    logic             out_of_range;
    logic [SEL_W-1:0] lowest;
    req_class_e       cls;

    // Any request on an unmapped bit makes the cycle a conflict
    always_comb begin
        out_of_range = 1'b0;
        for (int i = N_SRC; i < IN_W; i++) out_of_range = out_of_range | req[i];
    end

    // Lowest mapped set bit; IDLE_CODE when no mapped bit is set
    always_comb begin
        lowest = IDLE_CODE;
        for (int i = N_SRC - 1; i >= 0; i--) if (req[i]) lowest = SEL_W'(i);
    end

    // Strict mode refuses to pick a winner on a conflict
    always_comb begin
        cls         = classify(unsigned'($countones(req)), out_of_range);
        is_zero     = cls == CLS_ZERO;
        is_conflict = cls == CLS_CONFLICT;
        index       = (is_conflict && PRIORITY == 0) ? IDLE_CODE : lowest;
    end

endmodule

// File: rtl/bus_select_encoder.sv
// bus_select_encoder: registered request-to-bus-select encoder with hold window and conflict tracking
module bus_select_encoder
    import bus_enc_pkg::*;
#(
    parameter int IN_W        = 32,
    parameter int N_SRC       = 24,
    parameter int SEL_W       = 5,
    parameter int PRIORITY    = 0,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  req,
    input  logic             err_clr,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             holding,
    output logic             err_multi,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [SEL_W-1:0] IDLE_CODE = SEL_W'(idle_code(SEL_W));
    localparam int               HC_W      = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [SEL_W-1:0] index;
    logic             is_zero, is_conflict, valid_idx;
    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic             sel_valid_q, sel_valid_d;
    logic             holding_q, holding_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    onehot_prio_enc #(
        .IN_W    (IN_W),
        .N_SRC   (N_SRC),
        .SEL_W   (SEL_W),
        .PRIORITY(PRIORITY)
    ) u_enc (
        .req        (req),
        .index      (index),
        .is_zero    (is_zero),
        .is_conflict(is_conflict)
    );

    assign valid_idx = index != IDLE_CODE;

    // Next state, select and hold countdown; any conflict that resolves to no source drops to IDLE
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (valid_idx) begin
                    state_d = DRIVE;
                    sel_d   = index;
                end
            end
            DRIVE: begin
                if (valid_idx) begin
                    sel_d = index;
                end else if (is_zero && HOLD_CYCLES > 0) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                    sel_d   = IDLE_CODE;
                end
            end
            HOLD: begin
                if (valid_idx) begin
                    state_d = DRIVE;
                    sel_d   = index;
                end else if (!is_zero || hold_q == '0) begin
                    state_d = IDLE;
                    sel_d   = IDLE_CODE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = IDLE_CODE;
            end
        endcase
        sel_valid_d = state_d != IDLE;
        holding_d   = state_d == HOLD;
    end

    // Sticky error (a conflict beats a clear) and saturating conflict count
    always_comb begin
        err_d = is_conflict | (err_q & ~err_clr);
        cnt_d = (is_conflict && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= IDLE_CODE;
            hold_q      <= '0;
            sel_valid_q <= 1'b0;
            holding_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            hold_q      <= hold_d;
            sel_valid_q <= sel_valid_d;
            holding_q   <= holding_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sel          = sel_q;
    assign sel_valid    = sel_valid_q;
    assign holding      = holding_q;
    assign err_multi    = err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_select_encoder.sv
// tb_bus_select_encoder: table-driven scoreboard bench for strict, priority and small-counter variants
module tb_bus_select_encoder;
    import bus_enc_pkg::*;

    typedef struct {
        logic [31:0] req;
        logic        clr;
        int          sel, v, h, e, cnt;
        int          psel, pv, ph;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req = 32'h0;
    logic [31:0] req_c = 32'h0;
    logic        err_clr = 1'b0;

    logic [4:0] sel, sel_p, sel_c;
    logic       v, v_p, v_c, h, h_p, h_c, e, e_p, e_c;
    logic [7:0] cnt, cnt_p;
    logic [1:0] cnt_c;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    bus_select_encoder dut (
        .clk(clk), .rst_n(rst_n), .req(req), .err_clr(err_clr),
        .sel(sel), .sel_valid(v), .holding(h), .err_multi(e), .conflict_cnt(cnt)
    );

    bus_select_encoder #(.PRIORITY(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .req(req), .err_clr(err_clr),
        .sel(sel_p), .sel_valid(v_p), .holding(h_p), .err_multi(e_p), .conflict_cnt(cnt_p)
    );

    bus_select_encoder #(.HOLD_CYCLES(0), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .err_clr(1'b0),
        .sel(sel_c), .sel_valid(v_c), .holding(h_c), .err_multi(e_c), .conflict_cnt(cnt_c)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [31:0] r, input logic c, input int s, input int vv,
                                input int hh, input int ee, input int cc, input int ps,
                                input int pv, input int ph);
        vec_t x;
        x.req = r; x.clr = c; x.sel = s; x.v = vv; x.h = hh; x.e = ee; x.cnt = cc;
        x.psel = ps; x.pv = pv; x.ph = ph;
        vecs.push_back(x);
    endfunction

    always @(posedge clk) begin : monitor
        vec_t x;
        #1;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk($sformatf("sel req=%h", x.req), int'(sel), x.sel);
            chk($sformatf("sel_valid req=%h", x.req), int'(v), x.v);
            chk($sformatf("holding req=%h", x.req), int'(h), x.h);
            chk($sformatf("err_multi req=%h", x.req), int'(e), x.e);
            chk($sformatf("conflict_cnt req=%h", x.req), int'(cnt), x.cnt);
            chk($sformatf("prio sel req=%h", x.req), int'(sel_p), x.psel);
            chk($sformatf("prio sel_valid req=%h", x.req), int'(v_p), x.pv);
            chk($sformatf("prio holding req=%h", x.req), int'(h_p), x.ph);
        end
    end

    initial begin
        add(32'h10, 0, 4, 1, 0, 0, 0, 4, 1, 0);
        for (int i = 0; i < 24; i++) add(32'h1 << i, 0, i, 1, 0, 0, 0, i, 1, 0);
        add(32'h0100_0000, 0, 31, 0, 0, 1, 1, 31, 0, 0);
        add(32'h500, 0, 31, 0, 0, 1, 2, 8, 1, 0);
        add(32'h8, 0, 3, 1, 0, 1, 2, 3, 1, 0);
        add(32'h0, 0, 3, 1, 1, 1, 2, 3, 1, 1);
        add(32'h0, 0, 3, 1, 1, 1, 2, 3, 1, 1);
        add(32'h0, 0, 31, 0, 0, 1, 2, 31, 0, 0);
        add(32'h8, 0, 3, 1, 0, 1, 2, 3, 1, 0);
        add(32'h0, 0, 3, 1, 1, 1, 2, 3, 1, 1);
        add(32'h4, 0, 2, 1, 0, 1, 2, 2, 1, 0);
        add(32'h0, 0, 2, 1, 1, 1, 2, 2, 1, 1);
        add(32'h3, 1, 31, 0, 0, 1, 3, 0, 1, 0);
        add(32'h0, 1, 31, 0, 0, 0, 3, 0, 1, 1);
        add(32'h0, 0, 31, 0, 0, 0, 3, 0, 1, 1);
        add(32'h20, 0, 5, 1, 0, 0, 3, 5, 1, 0);
        add(32'h0, 0, 5, 1, 1, 0, 3, 5, 1, 1);

        req = 32'h10;
        #12;
        chk("reset sel", int'(sel), 31);
        chk("reset sel_valid", int'(v), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            req = vecs[i].req;
            err_clr = vecs[i].clr;
            if (i == 0) rst_n = 1'b1;
            exp_q.push_back(vecs[i]);
        end
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
        #2;
        chk("scoreboard drained", exp_q.size(), 0);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst sel", int'(sel), 31);
        chk("async rst sel_valid", int'(v), 0);
        chk("async rst holding", int'(h), 0);
        chk("async rst err_multi", int'(e), 0);
        chk("async rst conflict_cnt", int'(cnt), 0);
        chk("async rst prio sel", int'(sel_p), 31);
        chk("async rst prio holding", int'(h_p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 32'h0;
        err_clr = 1'b0;

        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_c = 32'h3;
            @(posedge clk);
            #1;
            chk($sformatf("sat cnt cycle %0d", k), int'(cnt_c), k < 3 ? k : 3);
            chk($sformatf("sat err cycle %0d", k), int'(e_c), 1);
            chk($sformatf("sat sel cycle %0d", k), int'(sel_c), 31);
        end
        @(negedge clk);
        req_c = 32'h1;
        @(posedge clk);
        #1;
        chk("nohold drive sel", int'(sel_c), 0);
        chk("nohold drive valid", int'(v_c), 1);
        @(negedge clk);
        req_c = 32'h0;
        @(posedge clk);
        #1;
        chk("nohold release sel", int'(sel_c), 31);
        chk("nohold release valid", int'(v_c), 0);
        chk("nohold release holding", int'(h_c), 0);
        chk("nohold cnt kept", int'(cnt_c), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
